// File: rtl/vga_capture.sv
// vga_capture: locks to a VGA timing stream, emits active pixels with
// coordinates, and produces a per-frame colour checksum.
module vga_capture #(
  parameter int HRES    = 640,
  parameter int VRES    = 480,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_b,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        pix_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [23:0] px_rgb,
  output logic        locked,
  output logic [7:0]  err_cnt,
  output logic [23:0] frame_sum,
  output logic        frame_sum_valid
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

  localparam logic [11:0] HT = 12'(H_TOTAL);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [9:0]  HR = 10'(HRES);
  localparam logic [9:0]  VR = 10'(VRES);

  state_t      state, state_nxt;
  logic        hs_q, vs_q;
  logic [10:0] h_cnt;
  logic [9:0]  x_cnt;
  logic [10:0] line_cnt;
  logic [9:0]  act_lines;
  logic        len_bad;
  logic [23:0] acc;
  logic        err_inc;

  logic        line_ev, frame_ev, act;
  logic [11:0] line_len;
  logic        len_ok, had_px, x_bad;
  logic [10:0] line_tot;
  logic [9:0]  act_tot, x_base, y_base;
  logic        line_fail, frame_fail, meas_fail;
  logic [23:0] rgb;

  assign line_ev  = pix_en & hs_q & ~hsync;
  assign frame_ev = pix_en & vs_q & ~vsync;
  assign act      = pix_en & blank_b;
  assign rgb      = {r, g, b};

  assign line_len = {1'b0, h_cnt} + 12'd1;
  assign len_ok   = line_len == HT;
  assign had_px   = x_cnt != '0;
  assign x_bad    = had_px & (x_cnt != HR);

  // Totals include a line event on this very sample.
  assign line_tot = line_cnt
                  + {10'd0, line_ev & (line_cnt != '1)};
  assign act_tot  = act_lines
                  + {9'd0, line_ev & had_px & (act_lines != '1)};
  assign x_base   = line_ev ? '0 : x_cnt;
  assign y_base   = frame_ev ? '0 : act_tot;

  assign line_fail  = line_ev & (~len_ok | x_bad);
  assign frame_fail = frame_ev
                    & ((line_tot != VT) | (act_tot != VR));
  assign meas_fail  = (line_tot != VT) | len_bad
                    | (line_ev & ~len_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_SEARCH;
    else if (pix_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_inc   = 1'b0;
    unique case (state)
      ST_SEARCH: begin
        if (frame_ev) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (frame_ev) begin
          if (meas_fail) begin
            state_nxt = ST_SEARCH;
            err_inc   = 1'b1;
          end else begin
            state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (line_fail | frame_fail) begin
          state_nxt = ST_SEARCH;
          err_inc   = 1'b1;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  assign locked = state == ST_LOCKED;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q            <= 1'b1;
      vs_q            <= 1'b1;
      h_cnt           <= '0;
      x_cnt           <= '0;
      line_cnt        <= '0;
      act_lines       <= '0;
      len_bad         <= 1'b0;
      acc             <= '0;
      err_cnt         <= '0;
      frame_sum       <= '0;
      frame_sum_valid <= 1'b0;
      pix_valid       <= 1'b0;
      px_x            <= '0;
      px_y            <= '0;
      px_rgb          <= '0;
    end else begin
      pix_valid       <= 1'b0;
      frame_sum_valid <= 1'b0;
      if (pix_en) begin
        hs_q <= hsync;
        vs_q <= vsync;
        if (line_ev) h_cnt <= '0;
        else if (h_cnt != '1) h_cnt <= h_cnt + 11'd1;
        x_cnt <= x_base
               + {9'd0, act & (x_base != '1)};
        line_cnt  <= frame_ev ? '0 : line_tot;
        act_lines <= frame_ev ? '0 : act_tot;
        // Length history restarts with each measured frame.
        if (frame_ev) len_bad <= 1'b0;
        else if (line_ev & ~len_ok) len_bad <= 1'b1;
        if (err_inc && err_cnt != 8'hff)
          err_cnt <= err_cnt + 8'd1;
        if (frame_ev) begin
          frame_sum       <= acc;
          frame_sum_valid <= 1'b1;
          acc             <= blank_b ? rgb : '0;
        end else if (act) begin
          acc <= acc + rgb;
        end
        if (act && state == ST_LOCKED) begin
          pix_valid <= 1'b1;
          px_x      <= x_base;
          px_y      <= y_base;
          px_rgb    <= rgb;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scaled-down VGA timing stream with pixel and
// frame-checksum scoreboards.
module tb_vga_capture;

  localparam int HRES    = 4;
  localparam int VRES    = 3;
  localparam int H_TOTAL = 8;
  localparam int V_TOTAL = 6;
  localparam int HA0     = 3;
  localparam int VA0     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        blank_b = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        pix_valid;
  logic [9:0]  px_x, px_y;
  logic [23:0] px_rgb;
  logic        locked;
  logic [7:0]  err_cnt;
  logic [23:0] frame_sum;
  logic        frame_sum_valid;

  int n_vec = 0;
  int n_fail = 0;
  int gap = 1;
  bit const_px = 1'b0;
  logic [23:0] acc_m = '0;
  logic [43:0] px_q[$];
  logic [23:0] fs_q[$];
  int px_cnt = 0;
  int fsv_cnt = 0;
  bit seen_lock = 1'b0;
  bit seen_unlock = 1'b0;
  logic [9:0] last_x = '0, last_y = '0;
  logic [43:0] pe;
  logic [23:0] fe;

  vga_capture #(
    .HRES(HRES), .VRES(VRES),
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .blank_b(blank_b),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .px_x(px_x), .px_y(px_y),
    .px_rgb(px_rgb), .locked(locked), .err_cnt(err_cnt),
    .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (locked === 1'b1) seen_lock = 1'b1;
    else seen_unlock = 1'b1;
    if (pix_valid === 1'b1) begin
      px_cnt++;
      last_x = px_x;
      last_y = px_y;
      n_vec++;
      if (px_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_extra got x=%0d y=%0d want no pix_valid",
                 px_x, px_y);
      end else begin
        pe = px_q.pop_front();
        if ({px_x, px_y, px_rgb} !== pe) begin
          n_fail++;
          $display("FAIL pix_data got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h",
                   px_x, px_y, px_rgb, pe[43:34], pe[33:24], pe[23:0]);
        end
      end
    end
    if (frame_sum_valid === 1'b1) begin
      fsv_cnt++;
      n_vec++;
      if (fs_q.size() == 0) begin
        n_fail++;
        $display("FAIL fsum_extra got %h want no strobe", frame_sum);
      end else begin
        fe = fs_q.pop_front();
        if (frame_sum !== fe) begin
          n_fail++;
          $display("FAIL fsum got %h want %h", frame_sum, fe);
        end
      end
    end
  end

  task automatic drive(input int v, input int h, input bit exp_px);
    logic [23:0] rgb;
    bit bl;
    bl = (v >= VA0) && (v < VA0 + VRES) && (h >= HA0) && (h < HA0 + HRES);
    rgb = const_px ? 24'h010203 : 24'($urandom);
    @(negedge clk);
    pix_en = 1'b1;
    hsync = !(h < 2);
    vsync = (v != 0);
    blank_b = bl;
    {r, g, b} = rgb;
    if (v == 0 && h == 0) begin
      fs_q.push_back(acc_m);
      acc_m = '0;
    end
    if (bl) begin
      acc_m = acc_m + rgb;
      if (exp_px) px_q.push_back({10'(h - HA0), 10'(v - VA0), rgb});
    end
    if (gap != 0) begin
      @(negedge clk);
      pix_en = 1'b0;
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      blank_b = 1'($urandom);
      {r, g, b} = 24'($urandom);
    end
  endtask

  task automatic drive_line(input int v, input int htot, input bit exp_px);
    for (int h = 0; h < htot; h++) drive(v, h, exp_px);
  endtask

  task automatic run_frame(input int nlines, input int px_until);
    for (int v = 0; v < nlines; v++) drive_line(v, H_TOTAL, v < px_until);
  endtask

  task automatic idle();
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pix_valid got %b want 0", pix_valid); end
    n_vec++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got %b want 0", locked); end
    n_vec++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
    n_vec++; if (frame_sum !== 24'd0 || frame_sum_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fsum got %h/%b want 0/0", frame_sum, frame_sum_valid); end
    n_vec++; if ({px_x, px_y, px_rgb} !== 44'd0) begin n_fail++; $display("FAIL rst_px got %0d/%0d/%h want 0/0/0", px_x, px_y, px_rgb); end
    rst = 1'b1;
  endtask

  task automatic test_lock();
    gap = 1;
    run_frame(V_TOTAL, 0);
    idle();
    n_vec++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got %b want 0", locked); end
    px_cnt = 0;
    run_frame(V_TOTAL, 99);
    idle();
    n_vec++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_2nd got %b want 1", locked); end
    n_vec++; if (px_cnt != HRES * VRES) begin n_fail++; $display("FAIL lock_px_count got %0d want %0d", px_cnt, HRES * VRES); end
    n_vec++; if (last_x !== 10'(HRES - 1) || last_y !== 10'(VRES - 1)) begin n_fail++; $display("FAIL last_px got %0d,%0d want %0d,%0d", last_x, last_y, HRES - 1, VRES - 1); end
    n_vec++; if (px_q.size() != 0) begin n_fail++; $display("FAIL lock_missing got %0d pending want 0", px_q.size()); end
    n_vec++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL lock_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_frame_sum();
    fsv_cnt = 0;
    const_px = 1'b1;
    run_frame(V_TOTAL, 99);
    run_frame(V_TOTAL, 99);
    const_px = 1'b0;
    run_frame(V_TOTAL, 99);
    idle();
    // 12 pixels of 0x010203
    n_vec++; if (frame_sum !== 24'h0C1824) begin n_fail++; $display("FAIL const_fsum got %h want 0c1824", frame_sum); end
    n_vec++; if (fsv_cnt != 3) begin n_fail++; $display("FAIL fsv_count got %0d want 3", fsv_cnt); end
  endtask

  task automatic test_short_line();
    px_cnt = 0;
    for (int v = 0; v < 3; v++) drive_line(v, H_TOTAL, 1'b1);
    drive_line(3, H_TOTAL - 1, 1'b1);
    n_vec++; if (locked !== 1'b1) begin n_fail++; $display("FAIL short_pre got %b want 1", locked); end
    drive(4, 0, 1'b0);
    n_vec++; if (locked !== 1'b0) begin n_fail++; $display("FAIL short_drop got %b want 0", locked); end
    for (int h = 1; h < H_TOTAL; h++) drive(4, h, 1'b0);
    drive_line(5, H_TOTAL, 1'b0);
    idle();
    n_vec++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL short_err got %0d want 1", err_cnt); end
    n_vec++; if (px_cnt != HRES * 2) begin n_fail++; $display("FAIL short_px got %0d want %0d", px_cnt, HRES * 2); end
    run_frame(V_TOTAL, 0);
    idle();
    n_vec++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early got %b want 0", locked); end
    px_cnt = 0;
    run_frame(V_TOTAL, 99);
    idle();
    n_vec++; if (locked !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL relock got %b/%0d want 1/1", locked, err_cnt); end
    n_vec++; if (px_cnt != HRES * VRES) begin n_fail++; $display("FAIL relock_px got %0d want %0d", px_cnt, HRES * VRES); end
  endtask

  task automatic test_coincident();
    seen_unlock = 1'b0;
    run_frame(V_TOTAL, 99);
    run_frame(V_TOTAL, 99);
    idle();
    n_vec++; if (seen_unlock !== 1'b0 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL coincident got unlock=%b err=%0d want 0/1", seen_unlock, err_cnt); end
  endtask

  task automatic test_midframe_reset();
    for (int v = 0; v < 3; v++) drive_line(v, H_TOTAL, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (locked !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst got locked=%b err=%0d want 0/0", locked, err_cnt); end
    n_vec++; if (frame_sum !== 24'd0 || {px_x, px_y, px_rgb} !== 44'd0) begin n_fail++; $display("FAIL mid_rst_data got %h/%0d/%0d/%h want zeros", frame_sum, px_x, px_y, px_rgb); end
    px_q.delete();
    fs_q.delete();
    acc_m = '0;
    @(negedge clk);
    rst = 1'b1;
    seen_lock = 1'b0;
    for (int v = 3; v < V_TOTAL; v++) drive_line(v, H_TOTAL, 1'b0);
    run_frame(V_TOTAL, 0);
    idle();
    n_vec++; if (seen_lock !== 1'b0) begin n_fail++; $display("FAIL mid_rst_early got seen_lock=%b want 0", seen_lock); end
    px_cnt = 0;
    run_frame(V_TOTAL, 99);
    idle();
    n_vec++; if (locked !== 1'b1 || px_cnt != HRES * VRES) begin n_fail++; $display("FAIL mid_rst_relock got %b/%0d want 1/%0d", locked, px_cnt, HRES * VRES); end
  endtask

  task automatic test_long_frames();
    @(negedge clk);
    rst = 1'b0;
    px_q.delete();
    fs_q.delete();
    acc_m = '0;
    @(negedge clk);
    rst = 1'b1;
    gap = 0;
    seen_lock = 1'b0;
    for (int f = 1; f <= 520; f++) begin
      run_frame(V_TOTAL + 1, 0);
      if (f == 20) begin
        idle();
        n_vec++; if (err_cnt !== 8'd10) begin n_fail++; $display("FAIL long_err20 got %0d want 10", err_cnt); end
      end
    end
    idle();
    n_vec++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL long_err_sat got %0d want 255", err_cnt); end
    n_vec++; if (seen_lock !== 1'b0) begin n_fail++; $display("FAIL long_lock got seen_lock=%b want 0", seen_lock); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_frame_sum();
    test_short_line();
    test_coincident();
    test_midframe_reset();
    test_long_frames();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter HRES, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter VRES, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter H_TOTAL, default 800, meaning pixel periods per line, sync plus porches included.
REQ-004 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-005 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port pix_en, input, 1, pixel strobe; inputs sampled only on clk edges with pix_en=1.
REQ-008 SHALL have port hsync, input, 1, horizontal sync, active-low.
REQ-009 SHALL have port vsync, input, 1, vertical sync, active-low.
REQ-010 SHALL have port blank_b, input, 1, 1 = active video.
REQ-011 SHALL have ports r, g, b, input, 8 each, pixel colour.
REQ-012 SHALL have port pix_valid, output, 1, one-clk pulse per captured active pixel.
REQ-013 SHALL have ports px_x, output, 10, and px_y, output, 10, coordinates of the captured pixel.
REQ-014 SHALL have port px_rgb, output, 24, {r,g,b} of the captured pixel.
REQ-015 SHALL have port locked, output, 1, timing matches parameters.
REQ-016 SHALL have port err_cnt, output, 8, saturating timing-error count.
REQ-017 SHALL have port frame_sum, output, 24, and port frame_sum_valid, output, 1, per-frame checksum and its one-clk strobe.

Function
REQ-018 SHALL register previous hsync/vsync samples; line event = sampled hsync 1->0; frame event = sampled vsync 1->0; a sample is a clk edge with pix_en=1.
REQ-019 SHALL keep an 11-bit h_cnt: on line event set to 0, else +1 per sample, saturating at 2047.
REQ-020 SHALL measure line length as h_cnt+1 at each line event (samples since previous line event).
REQ-021 SHALL keep x_cnt (active pixels this line, cleared on line event), line_cnt (line events since frame event), act_lines (lines with at least one active pixel, cleared on frame event).
REQ-022 SHALL implement FSM SEARCH -> MEASURE -> LOCKED; reset state SEARCH.
REQ-023 SEARCH: SHALL go to MEASURE on the first frame event.
REQ-024 MEASURE: SHALL on the next frame event go to LOCKED if line_cnt==V_TOTAL and every line-event length in the frame equalled H_TOTAL; otherwise SHALL return to SEARCH and increment err_cnt.
REQ-025 LOCKED: SHALL go to SEARCH and increment err_cnt on any violation: line length != H_TOTAL; an active line with x_cnt != HRES at its line event; at a frame event, line_cnt != V_TOTAL or act_lines != VRES.
REQ-026 locked SHALL be 1 exactly while FSM is LOCKED.
REQ-027 err_cnt SHALL saturate at 255; at most one increment per clk.
REQ-028 With blank_b=1 and FSM LOCKED, each sample SHALL produce, one clk later, pix_valid=1, px_x=x_cnt, px_y=act_lines, px_rgb={r,g,b}; no pix_valid in any other case.
REQ-029 When line and frame events occur on the same sample, SHALL apply line checks and counter updates first, then frame checks; line_cnt SHALL include that line.
REQ-030 SHALL accumulate the sum of {r,g,b} over active samples mod 2^24, across all FSM states.
REQ-031 At each frame event SHALL latch the sum into frame_sum, pulse frame_sum_valid for 1 clk, and clear the accumulator; a pixel on the same sample counts toward the new frame.
REQ-032 With pix_en=0, SHALL hold all counters, FSM state and sync history.

Reset
REQ-033 With rst=0, asynchronously: FSM=SEARCH, all counters 0, sync history=1, pix_valid=0, px_x=0, px_y=0, px_rgb=0, locked=0, err_cnt=0, frame_sum=0, frame_sum_valid=0.
REQ-034 Reset asserted mid-frame SHALL discard partial measurements; after release, lock SHALL require a fresh SEARCH -> MEASURE -> LOCKED sequence, i.e. at least 2 frame events.

Verification
REQ-035 Drive standard 640x480 timing with pix_en every other clk -> locked=1 after the 2nd frame event; then exactly 307200 pix_valid per frame; last pixel px_x=639, px_y=479.
REQ-036 Drive a constant pixel 0x010203 on all active samples -> frame_sum=(307200*0x010203) mod 2^24 each frame, with one frame_sum_valid pulse per frame.
REQ-037 While locked, shorten one line to 799 samples -> locked=0 at that line event; err_cnt=1; relock after 2 further clean frame events.
REQ-038 Drive 526 lines per frame -> never locked; err_cnt increments once per MEASURE frame, saturating at 255.
REQ-039 Assert rst mid-frame while locked -> all outputs zero immediately; after release, no pix_valid until relocked.
REQ-040 Make hsync and vsync fall on the same sample -> the line is counted in line_cnt=525 and the frame check passes.
